// File: rtl/cachepool_pkg.sv
// Shared types and constants for the cachepool boot sequencer.
package cachepool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_RSP,
    ST_WAKE,
    ST_WAIT_EOC,
    ST_DONE,
    ST_ERROR
  } boot_state_e;

  localparam int unsigned BOOT_CTRL_OFFSET = 32'h58;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [3:0] lowest_set(input logic [15:0] mask);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cachepool_boot_watchdog.sv
// Cycle watchdog: counts enabled cycles, expires on the Limit-th one (Limit=0 never expires).
module cachepool_boot_watchdog #(
  parameter int unsigned Limit = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (Limit != 0) && enable_i && (cnt_q == Limit - 1);

endmodule

// File: rtl/cachepool_boot_sequencer.sv
// Writes the boot entry point into each enabled cluster, pulses debug_req to wake
// the cores, then waits for every enabled cluster to report end-of-computation.
module cachepool_boot_sequencer
  import cachepool_pkg::*;
#(
  parameter int unsigned NumClusters        = 4,
  parameter int unsigned NumCoresPerCluster = 4,
  parameter int unsigned AddrWidth          = 48,
  parameter int unsigned DataWidth          = 32,
  parameter logic [AddrWidth-1:0] PeriBase      = AddrWidth'(32'h5100_0000),
  parameter logic [AddrWidth-1:0] ClusterStride = AddrWidth'(32'h0004_0000),
  parameter int unsigned BootCtrlOffset     = BOOT_CTRL_OFFSET,
  parameter int unsigned WakeCycles         = 1,
  parameter int unsigned TimeoutCycles      = 0
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      start_i,
  input  logic [DataWidth-1:0]                      entry_point_i,
  input  logic [NumClusters-1:0]                    cluster_en_i,
  output logic [AddrWidth-1:0]                      req_addr_o,
  output logic [DataWidth-1:0]                      req_data_o,
  output logic                                      req_write_o,
  output logic [DataWidth/8-1:0]                    req_strb_o,
  output logic                                      req_valid_o,
  input  logic                                      req_ready_i,
  input  logic                                      rsp_valid_i,
  input  logic                                      rsp_error_i,
  output logic                                      rsp_ready_o,
  output logic [NumClusters*NumCoresPerCluster-1:0] debug_req_o,
  input  logic [NumClusters-1:0]                    eoc_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      error_o,
  output logic                                      timeout_o,
  output logic [NumClusters-1:0]                    eoc_seen_o
);

  boot_state_e            state_q, state_d;
  logic [DataWidth-1:0]   entry_q, entry_d;
  logic [NumClusters-1:0] en_q, en_d;
  logic [NumClusters-1:0] pending_q, pending_d;
  logic [NumClusters-1:0] eoc_seen_q, eoc_seen_d;
  logic [31:0]            wake_cnt_q, wake_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   wd_expire;
  logic [3:0]             cur_k;
  logic                   in_write, in_wake;

  cachepool_boot_watchdog #(
    .Limit(TimeoutCycles)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .enable_i(state_q == ST_WAIT_EOC),
    .clear_i (state_q != ST_WAIT_EOC),
    .expire_o(wd_expire)
  );

  // pending_q only changes on a completed handshake, so the target is stable under stall.
  assign cur_k = lowest_set(16'(pending_q));

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    en_d       = en_q;
    pending_d  = pending_q;
    eoc_seen_d = eoc_seen_q;
    wake_cnt_d = wake_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          eoc_seen_d = '0;
          timeout_d  = 1'b0;
          en_d       = cluster_en_i;
          if (cluster_en_i != '0) begin
            entry_d   = entry_point_i;
            pending_d = cluster_en_i;
            state_d   = ST_WRITE;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        if (req_ready_i) begin
          pending_d = pending_q & (pending_q - 1'b1);
          state_d   = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid_i) begin
          if (rsp_error_i) begin
            state_d = ST_ERROR;
          end else if (pending_q != '0) begin
            state_d = ST_WRITE;
          end else begin
            wake_cnt_d = '0;
            state_d    = ST_WAKE;
          end
        end
      end
      ST_WAKE: begin
        eoc_seen_d = eoc_seen_q | (eoc_i & en_q);
        if (wake_cnt_q == WakeCycles - 1) state_d = ST_WAIT_EOC;
        else                              wake_cnt_d = wake_cnt_q + 32'd1;
      end
      ST_WAIT_EOC: begin
        eoc_seen_d = eoc_seen_q | (eoc_i & en_q);
        // Completion in the expiry cycle takes priority over the timeout.
        if (eoc_seen_d == en_q) begin
          state_d = ST_DONE;
        end else if (wd_expire) begin
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      entry_q    <= '0;
      en_q       <= '0;
      pending_q  <= '0;
      eoc_seen_q <= '0;
      wake_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      en_q       <= en_d;
      pending_q  <= pending_d;
      eoc_seen_q <= eoc_seen_d;
      wake_cnt_q <= wake_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign in_write = (state_q == ST_WRITE);
  assign in_wake  = (state_q == ST_WAKE);

  assign req_valid_o = in_write;
  assign req_write_o = in_write;
  assign req_strb_o  = {(DataWidth/8){in_write}};
  assign req_data_o  = in_write ? entry_q : '0;
  assign req_addr_o  = in_write ? PeriBase + ClusterStride * AddrWidth'(cur_k)
                                  + AddrWidth'(BootCtrlOffset) : '0;
  assign rsp_ready_o = (state_q == ST_WAIT_RSP);

  always_comb begin
    debug_req_o = '0;
    for (int c = 0; c < NumClusters; c++) begin
      debug_req_o[c*NumCoresPerCluster +: NumCoresPerCluster] =
        {NumCoresPerCluster{in_wake && en_q[c]}};
    end
  end

  assign busy_o     = in_write || in_wake || (state_q == ST_WAIT_RSP) ||
                      (state_q == ST_WAIT_EOC);
  assign done_o     = (state_q == ST_DONE);
  assign error_o    = (state_q == ST_ERROR);
  assign timeout_o  = timeout_q;
  assign eoc_seen_o = eoc_seen_q;

endmodule
